mc_control: RTL and testbench

- Multicycle main control FSM for the datapath. It sits directly upstream of the ALU and generates the 4-bit ALU operation code plus every datapath mux, register-file and memory enable.
- It consumes the ALU Zero flag to resolve beq.
- Instruction subset: R-type (add/sub/and/or/nor/slt), lw, sw, beq, j, addi.
- It also counts retired instructions and flags illegal encodings.

---
 rtl/mc_control.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute for the R-type, lw, sw,
// beq, j and addi subset, drives every datapath enable, counts retired instructions.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | first cycle after reset, all enables low
// FETCH  | read instruction at PC, PC+4 -> PC and IR load when mem_ready
// DECODE | register read, branch target precomputed into ALUOut
// MEMADR | base + sign-extended offset for lw/sw
// MEMRD  | data read at ALUOut, holds for mem_ready
// MEMWB  | MDR -> rt
// MEMWR  | data write at ALUOut, holds for mem_ready
// EXEC   | R-type ALU operation on A,B
// ALUWB  | ALUOut -> rd
// BRANCH | A-B compare, PC <- ALUOut when zero
// JUMP   | PC <- jump target
// ADDIEX | A + sign-extended imm
// ADDIWB | ALUOut -> rt
// HALT   | trapped on illegal encoding, waits for reset
module mc_control #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ior,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM4 = 2'b11;

  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  logic [3:0] state;
  logic [3:0] state_nx;
  logic       retire;
  logic       flag_illegal;
  logic       funct_ok;
  logic [3:0] funct_alu_op;
  logic [3:0] exec_alu_op;
  logic       is_store;
  logic       pc_write;
  logic       pc_write_cond;

  always_comb begin
    funct_ok     = 1'b1;
    funct_alu_op = ALU_AND;
    case (funct)
      6'h20:   funct_alu_op = ALU_ADD;
      6'h22:   funct_alu_op = ALU_SUB;
      6'h24:   funct_alu_op = ALU_AND;
      6'h25:   funct_alu_op = ALU_OR;
      6'h27:   funct_alu_op = ALU_NOR;
      6'h2A:   funct_alu_op = ALU_SLT;
      default: funct_ok     = 1'b0;
    endcase
  end

  always_comb begin
    state_nx     = state;
    retire       = 1'b0;
    flag_illegal = 1'b0;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (funct_ok) state_nx = S_EXEC;
            else          flag_illegal = 1'b1;
          end
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI:      state_nx = S_ADDIEX;
          default:      flag_illegal = 1'b1;
        endcase
        if (flag_illegal) state_nx = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR: state_nx = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end
      end
      S_EXEC:   state_nx = S_ALUWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_nx = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // The ALU code and lw/sw choice are captured in DECODE so later states decode from registers only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      illegal     <= 1'b0;
      retired     <= '0;
      exec_alu_op <= ALU_AND;
      is_store    <= 1'b0;
    end else begin
      state <= state_nx;
      if (flag_illegal) illegal <= 1'b1;
      if (retire)       retired <= retired + CNT_W'(1);
      if (state == S_DECODE) begin
        exec_alu_op <= funct_alu_op;
        is_store    <= (op == OP_SW);
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior           = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_REG;
    pc_source     = 2'b00;
    alu_op        = ALU_AND;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        alu_op    = ALU_ADD;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = ASB_IMM4;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        ior      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        ior       = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = exec_alu_op;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCS_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-level phase model builds the expected per-cycle
// control vector; a negedge process compares it against the DUT every cycle.
module tb_mc_control;

  typedef enum int {
    PH_IDLE, PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
    PH_EXEC, PH_ALUWB, PH_BRANCH, PH_JUMP, PH_ADDIEX, PH_ADDIWB, PH_HALT
  } ph_e;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] op, funct;
  logic zero, mem_ready;

  logic pc_en, ior, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic illegal;
  logic [31:0] retired;

  logic d2_pc_en, d2_ior, d2_mem_read, d2_mem_write, d2_ir_write, d2_reg_dst, d2_mem_to_reg;
  logic d2_reg_write, d2_alu_src_a, d2_illegal;
  logic [1:0] d2_alu_src_b, d2_pc_source;
  logic [3:0] d2_alu_op;
  logic [31:0] d2_retired;

  logic d3_pc_en, d3_ior, d3_mem_read, d3_mem_write, d3_ir_write, d3_reg_dst, d3_mem_to_reg;
  logic d3_reg_write, d3_alu_src_a, d3_illegal;
  logic [1:0] d3_alu_src_b, d3_pc_source;
  logic [3:0] d3_alu_op;
  logic [1:0] d3_retired;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ior(ior), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op), .illegal(illegal),
    .retired(retired));

  mc_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut_notrap (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(d2_pc_en), .ior(d2_ior), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .ir_write(d2_ir_write), .reg_dst(d2_reg_dst), .mem_to_reg(d2_mem_to_reg),
    .reg_write(d2_reg_write), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .pc_source(d2_pc_source), .alu_op(d2_alu_op), .illegal(d2_illegal), .retired(d2_retired));

  mc_control #(.CNT_W(2), .TRAP_ON_ILLEGAL(1'b1)) dut_w2 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(d3_pc_en), .ior(d3_ior), .mem_read(d3_mem_read), .mem_write(d3_mem_write),
    .ir_write(d3_ir_write), .reg_dst(d3_reg_dst), .mem_to_reg(d3_mem_to_reg),
    .reg_write(d3_reg_write), .alu_src_a(d3_alu_src_a), .alu_src_b(d3_alu_src_b),
    .pc_source(d3_pc_source), .alu_op(d3_alu_op), .illegal(d3_illegal), .retired(d3_retired));

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_valid = 1'b0;
  logic [16:0] exp_c;
  ph_e         exp_ph;
  logic [31:0] exp_ret;
  logic        exp_ill;

  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_en, ior, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, pc_source, alu_op};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rtype_aop(input logic [5:0] f);
    case (f)
      6'h20:   return 4'd2;
      6'h22:   return 4'd6;
      6'h24:   return 4'd0;
      6'h25:   return 4'd1;
      6'h27:   return 4'd12;
      6'h2A:   return 4'd7;
      default: return 4'hF;
    endcase
  endfunction

  // Control vector each phase must show, straight from the per-state output lists.
  function automatic logic [16:0] exp_ctrl(input ph_e ph, input bit mr, input bit z,
                                           input logic [3:0] aop);
    logic pcw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, psrc;
    logic [3:0] ao;
    {pcw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'd0; psrc = 2'd0; ao = 4'd0;
    case (ph)
      PH_FETCH:  begin mrd = 1; asb = 2'd1; ao = 4'd2; pcw = mr; irw = mr; end
      PH_DECODE: begin asb = 2'd3; ao = 4'd2; end
      PH_MEMADR: begin asa = 1; asb = 2'd2; ao = 4'd2; end
      PH_MEMRD:  begin mrd = 1; io = 1; end
      PH_MEMWB:  begin rw = 1; m2r = 1; end
      PH_MEMWR:  begin mwr = 1; io = 1; end
      PH_EXEC:   begin asa = 1; ao = aop; end
      PH_ALUWB:  begin rw = 1; rdst = 1; end
      PH_BRANCH: begin asa = 1; ao = 4'd6; psrc = 2'd1; pwc = 1; end
      PH_JUMP:   begin psrc = 2'd2; pcw = 1; end
      PH_ADDIEX: begin asa = 1; asb = 2'd2; ao = 4'd2; end
      PH_ADDIWB: rw = 1;
      default: ;
    endcase
    return {pcw | (pwc & z), io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, psrc, ao};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk({"ctrl@", exp_ph.name()}, act_ctrl, exp_c);
      chk({"retired@", exp_ph.name()}, retired, exp_ret);
      chk({"illegal@", exp_ph.name()}, illegal, exp_ill);
      chk({"retired_w2@", exp_ph.name()}, d3_retired, exp_ret[1:0]);
    end
  end

  // One clock of a phase; called just after a rising edge.
  task automatic step(input ph_e ph, input bit mr, input bit z, input logic [3:0] aop = 4'd0);
    mem_ready = mr;
    zero      = z;
    exp_ph    = ph;
    exp_c     = exp_ctrl(ph, mr, z, aop);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ret = '0;
    exp_ill = 1'b0;
    step(PH_IDLE, 1, 1);
    rst = 1'b0;
    step(PH_IDLE, 1, 1);
  endtask

  // Phase sequence of one instruction; returns cycles spent from FETCH entry.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fwait,
                           input int mwait, input bit z, output int ncyc);
    bit legal;
    ncyc  = 0;
    legal = 1'b1;
    op    = o;
    funct = f;
    for (int i = 0; i < fwait; i++) begin step(PH_FETCH, 0, 1); ncyc++; end
    step(PH_FETCH, 1, 1); ncyc++;
    step(PH_DECODE, 0, 1); ncyc++;
    if (o == 6'h00 && rtype_aop(f) != 4'hF) begin
      step(PH_EXEC, 1, 1, rtype_aop(f)); step(PH_ALUWB, 1, 1); ncyc += 2;
    end else if (o == 6'h23) begin
      step(PH_MEMADR, 1, 1); ncyc++;
      for (int i = 0; i < mwait; i++) begin step(PH_MEMRD, 0, 1); ncyc++; end
      step(PH_MEMRD, 1, 1); step(PH_MEMWB, 0, 1); ncyc += 2;
    end else if (o == 6'h2B) begin
      step(PH_MEMADR, 1, 1); ncyc++;
      for (int i = 0; i < mwait; i++) begin step(PH_MEMWR, 0, 1); ncyc++; end
      step(PH_MEMWR, 1, 1); ncyc++;
    end else if (o == 6'h04) begin
      step(PH_BRANCH, 1, z); ncyc++;
    end else if (o == 6'h02) begin
      step(PH_JUMP, 1, 1); ncyc++;
    end else if (o == 6'h08) begin
      step(PH_ADDIEX, 1, 1); step(PH_ADDIWB, 0, 1); ncyc += 2;
    end else begin
      legal   = 1'b0;
      exp_ill = 1'b1;
    end
    if (legal) exp_ret++;
  endtask

  logic [5:0] rfuncts [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  initial begin
    int nc;
    rst = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    exp_ret = '0; exp_ill = 1'b0; exp_c = '0; exp_ph = PH_IDLE;

    do_reset();
    run_instr(6'h00, 6'h20, 0, 0, 1, nc);
    chk("t1_rtype_cycles", nc, 4);
    chk("t1_retired", retired, 1);

    run_instr(6'h23, 6'h00, 0, 3, 1, nc);
    chk("t2_lw_cycles", nc, 8);
    chk("t2_retired", retired, 2);

    run_instr(6'h04, 6'h00, 0, 0, 1, nc);
    chk("t3_beq_cycles", nc, 3);
    chk("t3_retired_taken", retired, 3);
    run_instr(6'h04, 6'h00, 0, 0, 0, nc);
    chk("t3_retired_not_taken", retired, 4);

    foreach (rfuncts[i]) run_instr(6'h00, rfuncts[i], 0, 0, 1, nc);
    chk("t4_retired", retired, 10);

    run_instr(6'h08, 6'h00, 0, 0, 1, nc);
    chk("addi_cycles", nc, 4);
    run_instr(6'h02, 6'h00, 0, 0, 1, nc);
    chk("j_cycles", nc, 3);
    run_instr(6'h2B, 6'h00, 0, 0, 1, nc);
    chk("sw_cycles", nc, 4);
    run_instr(6'h2B, 6'h00, 2, 2, 1, nc);
    chk("sw_wait_cycles", nc, 8);
    chk("retired_14", retired, 14);
    chk("retired_w2_wrap", d3_retired, 2);

    run_instr(6'h3F, 6'h00, 0, 0, 1, nc);
    chk("t5_notrap_illegal", d2_illegal, 1);
    chk("t5_notrap_fetch_mem_read", d2_mem_read, 1);
    chk("t5_notrap_fetch_alu_src_b", d2_alu_src_b, 1);
    chk("t5_notrap_retired", d2_retired, 14);
    for (int i = 0; i < 10; i++) step(PH_HALT, 1, 1);
    chk("t5_halt_retired", retired, 14);
    chk("t5_halt_illegal", illegal, 1);

    do_reset();
    run_instr(6'h00, 6'h21, 0, 0, 1, nc);
    for (int i = 0; i < 2; i++) step(PH_HALT, 1, 1);
    chk("bad_funct_illegal", illegal, 1);

    do_reset();
    run_instr(6'h23, 6'h00, 0, 0, 1, nc);
    op = 6'h2B; funct = 6'h00;
    step(PH_FETCH, 1, 1);
    step(PH_DECODE, 0, 1);
    step(PH_MEMADR, 1, 1);
    mem_ready = 1'b0;
    exp_ph = PH_MEMWR;
    exp_c  = exp_ctrl(PH_MEMWR, 0, 1, 4'd0);
    #2;
    chk("t6_mem_write_before_rst", mem_write, 1);
    chk("t6_retired_before_rst", retired, 1);
    exp_ph = PH_IDLE; exp_c = '0; exp_ret = '0; exp_ill = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_mem_write_async_drop", mem_write, 0);
    chk("t6_retired_cleared", retired, 0);
    chk("t6_illegal_cleared", illegal, 0);
    @(posedge clk);
    #1;
    step(PH_IDLE, 1, 1);
    rst = 1'b0;
    step(PH_IDLE, 1, 1);
    run_instr(6'h02, 6'h00, 0, 0, 1, nc);
    chk("t6_restart_retired", retired, 1);

    exp_valid = 1'b0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
